// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if
// Groups the receive controller's counter handshake and its output register
// bus into one bundle.
//   master : the frame controller. Takes the counter state in, and drives the
//            counter enable, the parity enable and the received-byte bus.
//   slave  : the edge/bit counter plus whoever consumes the received byte.
// Signals:
//   edge_cnt, bit_cnt, edge_cnt_max : counter position within the frame
//   edge_cnt_enable, par_en_cnt     : counter controls
//   P_DATA, data_valid              : received byte and its 1-cycle strobe
//   par_err, stp_err, strt_glitch   : frame status
//   busy                            : a frame is in progress
interface uart_rx_ctrl_if;
   logic [5:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       edge_cnt_max;
   logic       edge_cnt_enable;
   logic       par_en_cnt;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;
   logic       strt_glitch;
   logic       busy;

   modport master (
      input  edge_cnt, bit_cnt, edge_cnt_max,
      output edge_cnt_enable, par_en_cnt,
      output P_DATA, data_valid, par_err, stp_err, strt_glitch, busy
   );

   modport slave (
      output edge_cnt, bit_cnt, edge_cnt_max,
      input  edge_cnt_enable, par_en_cnt,
      input  P_DATA, data_valid, par_err, stp_err, strt_glitch, busy
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// UART receive frame controller in the clk_RX domain. Synchronizes RX_IN,
// takes a 3-point majority vote around the middle of every bit, sequences
// the external edge/bit counter, deserializes LSB first and checks the
// start, parity and stop bits.
// Ports:
//   clk_RX   : oversampling clock
//   rst      : synchronous active-low reset
//   RX_IN    : serial line, idle high
//   prescale : oversampling ratio (8/16/32, anything else behaves as 8)
//   PAR_EN   : parity bit present
//   PAR_TYP  : 0 even, 1 odd
//   bus      : counter handshake and received-byte bus (master side)
module uart_rx_ctrl #(
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_RX,
   input  logic                  rst,
   input  logic                  RX_IN,
   input  logic [5:0]            prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   uart_rx_ctrl_if.master        bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t     state, state_nx;
   logic       rx_s;

   // frame-latched configuration
   logic       cfg_par_en;
   logic       cfg_par_typ;
   logic [5:0] cfg_half;
   logic [5:0] half_in;

   logic [2:0] samp;
   logic       vote;
   logic [7:0] shift;
   logic       par_bad;

   // FSM decode strobes
   logic       start_go;
   logic       glitch_go;
   logic       shift_go;
   logic       par_go;
   logic       stop_go;

   // registered outputs
   logic [7:0] p_data_q;
   logic       data_valid_q;
   logic       par_err_q;
   logic       stp_err_q;
   logic       strt_glitch_q;

   // ------------------------------------------------------------------
   // Input synchronizer. Flops come out of reset at the idle level so a
   // reset never looks like a start edge.
   // ------------------------------------------------------------------
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign rx_s = RX_IN;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         always_ff @(posedge clk_RX) begin
            if (!rst) begin
               sync_q <= '1;
            end else begin
               sync_q[0] <= RX_IN;
               for (int i = 1; i < SYNC_STAGES; i++)
                  sync_q[i] <= sync_q[i-1];
            end
         end
         assign rx_s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // Half-bit point; unsupported ratios fall back to 8, like the counter.
   always_comb begin
      case (prescale)
         6'd32:   half_in = 6'd16;
         6'd16:   half_in = 6'd8;
         default: half_in = 6'd4;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk_RX) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      start_go  = 1'b0;
      glitch_go = 1'b0;
      shift_go  = 1'b0;
      par_go    = 1'b0;
      stop_go   = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_nx = START;
               start_go = 1'b1;
            end
         end
         START: begin
            if (bus.edge_cnt_max) begin
               if (vote) begin
                  state_nx  = IDLE;
                  glitch_go = 1'b1;
               end else begin
                  state_nx  = DATA;
               end
            end
         end
         DATA: begin
            if (bus.edge_cnt_max) begin
               shift_go = 1'b1;
               if (bus.bit_cnt == 4'd8)
                  state_nx = cfg_par_en ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bus.edge_cnt_max) begin
               par_go   = 1'b1;
               state_nx = STOP;
            end
         end
         STOP: begin
            if (bus.edge_cnt_max) begin
               stop_go  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Config latch, taken on the IDLE->START edge and held for the frame.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_RX) begin
      if (!rst) begin
         cfg_par_en  <= 1'b0;
         cfg_par_typ <= 1'b0;
         cfg_half    <= 6'd0;
      end else if (start_go) begin
         cfg_par_en  <= PAR_EN;
         cfg_par_typ <= PAR_TYP;
         cfg_half    <= half_in;
      end
   end

   // ------------------------------------------------------------------
   // 3-point sampler around mid-bit. Only the three sample slots can
   // influence the vote; anything else on the line mid-bit is ignored.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_RX) begin
      if (!rst) begin
         samp <= 3'b000;
      end else if (state != IDLE) begin
         if (bus.edge_cnt == cfg_half - 6'd1) samp[0] <= rx_s;
         if (bus.edge_cnt == cfg_half)        samp[1] <= rx_s;
         if (bus.edge_cnt == cfg_half + 6'd1) samp[2] <= rx_s;
      end
   end

   assign vote = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

   // ------------------------------------------------------------------
   // Deserializer and parity check
   // ------------------------------------------------------------------
   always_ff @(posedge clk_RX) begin
      if (!rst) begin
         shift   <= 8'h00;
         par_bad <= 1'b0;
      end else begin
         if (shift_go) shift <= {vote, shift[7:1]};
         if (start_go)
            par_bad <= 1'b0;
         else if (par_go)
            par_bad <= (vote != (^shift ^ cfg_par_typ));
      end
   end

   // ------------------------------------------------------------------
   // Output register. Status updates on every stop decision; the byte is
   // only committed for a clean frame, otherwise the previous byte stays.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_RX) begin
      if (!rst) begin
         p_data_q      <= 8'h00;
         data_valid_q  <= 1'b0;
         par_err_q     <= 1'b0;
         stp_err_q     <= 1'b0;
         strt_glitch_q <= 1'b0;
      end else begin
         data_valid_q  <= 1'b0;
         strt_glitch_q <= glitch_go;
         if (stop_go) begin
            stp_err_q <= ~vote;
            par_err_q <= par_bad;
            if (vote && !par_bad) begin
               p_data_q     <= shift;
               data_valid_q <= 1'b1;
            end
         end
      end
   end

   // Enable leaves with the state so a glitch exit clears the counter.
   assign bus.edge_cnt_enable = (state != IDLE);
   assign bus.busy            = (state != IDLE);
   assign bus.par_en_cnt      = cfg_par_en;
   assign bus.P_DATA          = p_data_q;
   assign bus.data_valid      = data_valid_q;
   assign bus.par_err         = par_err_q;
   assign bus.stp_err         = stp_err_q;
   assign bus.strt_glitch     = strt_glitch_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
// Drives serial frames into uart_rx_ctrl, models the external edge/bit
// counter, and checks received frames against a scoreboard queue filled as
// each frame is sent.
module tb_uart_rx_ctrl;

   logic       clk_RX = 1'b0;
   logic       rst;
   logic       line;
   logic       glitch;
   logic       RX_IN;
   logic [5:0] prescale;
   logic       PAR_EN;
   logic       PAR_TYP;

   always #5 clk_RX = ~clk_RX;

   assign RX_IN = line ^ glitch;

   uart_rx_ctrl_if bus ();

   uart_rx_ctrl #(.SYNC_STAGES(2)) dut (
      .clk_RX   (clk_RX),
      .rst      (rst),
      .RX_IN    (RX_IN),
      .prescale (prescale),
      .PAR_EN   (PAR_EN),
      .PAR_TYP  (PAR_TYP),
      .bus      (bus.master)
   );

   // ---------------- counter model ----------------
   int         pr;
   logic [3:0] last_bit;
   logic [5:0] ec;
   logic [3:0] bc;

   always_comb begin
      case (prescale)
         6'd32:   pr = 32;
         6'd16:   pr = 16;
         default: pr = 8;
      endcase
   end

   assign last_bit = bus.par_en_cnt ? 4'd10 : 4'd9;

   always_ff @(posedge clk_RX) begin
      if (!rst || !bus.edge_cnt_enable) begin
         ec <= 6'd0;
         bc <= 4'd0;
      end else if (int'(ec) == pr - 1) begin
         ec <= 6'd0;
         bc <= (bc == last_bit) ? 4'd0 : bc + 4'd1;
      end else begin
         ec <= ec + 6'd1;
      end
   end

   assign bus.edge_cnt     = ec;
   assign bus.bit_cnt      = bc;
   assign bus.edge_cnt_max = (int'(ec) == pr - 1);

   // ---------------- checking ----------------
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic       valid;
      logic       perr;
      logic       serr;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] exp_last = 8'h00;
   int         n_valid_exp = 0;

   task automatic push_exp(input logic [7:0] d, input logic good, input logic perr, input logic serr);
      exp_t e;
      if (good) begin
         exp_last = d;
         n_valid_exp++;
      end
      e.data  = exp_last;
      e.valid = good;
      e.perr  = perr;
      e.serr  = serr;
      sbq.push_back(e);
   endtask

   // ---------------- monitor ----------------
   int   cyc = 0;
   int   dv_cnt = 0;
   int   sg_cnt = 0;
   int   dv_time[$];
   logic res_due = 1'b0;
   logic dv_chk2 = 1'b0;

   always @(posedge clk_RX) cyc++;

   always @(negedge clk_RX) begin
      exp_t e;
      if (bus.data_valid) begin
         dv_cnt++;
         dv_time.push_back(cyc);
      end
      if (bus.strt_glitch) sg_cnt++;
      if (dv_chk2) begin
         dv_chk2 = 1'b0;
         chk("dv_width", {31'd0, bus.data_valid}, 32'd0);
      end
      if (res_due) begin
         res_due = 1'b0;
         chk("sb_nonempty", {31'd0, sbq.size() > 0}, 32'd1);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("data_valid", {31'd0, bus.data_valid}, {31'd0, e.valid});
            chk("P_DATA",     {24'd0, bus.P_DATA},     {24'd0, e.data});
            chk("par_err",    {31'd0, bus.par_err},    {31'd0, e.perr});
            chk("stp_err",    {31'd0, bus.stp_err},    {31'd0, e.serr});
            if (e.valid) dv_chk2 = 1'b1;
         end
      end
      // stop-bit decision cycle: results are visible one cycle later
      if (rst && bus.busy && bus.edge_cnt_max && bus.bit_cnt == last_bit)
         res_due = 1'b1;
   end

   // single-cycle line inversion landing on the middle sample of a data bit
   logic gl_arm  = 1'b0;
   logic gl_done = 1'b0;
   initial glitch = 1'b0;

   always @(negedge clk_RX) begin
      if (gl_arm && bus.busy && bus.bit_cnt == 4'd3 && bus.edge_cnt == 6'd14) begin
         glitch  = 1'b1;
         gl_arm  = 1'b0;
         gl_done = 1'b1;
      end else begin
         glitch  = 1'b0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      line = 1'b1;
      repeat (n) @(negedge clk_RX);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                             input logic sbit, input int p, input int nbits);
      logic [10:0] fr;
      int          n;
      fr      = '1;
      fr[0]   = 1'b0;
      fr[8:1] = d;
      if (pe) begin
         fr[9]  = pbit;
         fr[10] = sbit;
         n      = 11;
      end else begin
         fr[9]  = sbit;
         n      = 10;
      end
      if (nbits > 0 && nbits < n) n = nbits;
      for (int i = 0; i < n; i++) begin
         line = fr[i];
         repeat (p) @(negedge clk_RX);
      end
      line = 1'b1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_P_DATA"},  {24'd0, bus.P_DATA}, 32'd0);
      chk({tag, "_dv"},      {31'd0, bus.data_valid}, 32'd0);
      chk({tag, "_perr"},    {31'd0, bus.par_err}, 32'd0);
      chk({tag, "_serr"},    {31'd0, bus.stp_err}, 32'd0);
      chk({tag, "_sg"},      {31'd0, bus.strt_glitch}, 32'd0);
      chk({tag, "_busy"},    {31'd0, bus.busy}, 32'd0);
      chk({tag, "_en"},      {31'd0, bus.edge_cnt_enable}, 32'd0);
      chk({tag, "_paren"},   {31'd0, bus.par_en_cnt}, 32'd0);
   endtask

   initial begin
      int wait_n;
      int gap;
      line     = 1'b1;
      rst      = 1'b0;
      prescale = 6'd8;
      PAR_EN   = 1'b1;
      PAR_TYP  = 1'b0;
      repeat (3) @(negedge clk_RX);
      chk_reset_outs("rst0");
      rst = 1'b1;
      idle(10);

      // even parity, clean frame
      push_exp(8'hA5, 1'b1, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8, 0);
      idle(20);
      chk("busy_after_A5", {31'd0, bus.busy}, 32'd0);

      // bad parity, then a clean frame clears par_err
      push_exp(8'hA5, 1'b0, 1'b1, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 8, 0);
      idle(20);
      push_exp(8'h3C, 1'b1, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 8, 0);
      idle(20);

      // framing error at x16, then recovery
      prescale = 6'd16;
      PAR_EN   = 1'b0;
      idle(2);
      push_exp(8'h00, 1'b0, 1'b0, 1'b1);
      send_frame(8'h00, 1'b0, 1'b0, 1'b0, 16, 0);
      idle(40);
      push_exp(8'hFF, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 16, 0);
      idle(40);

      // unsupported ratio runs at 8
      prescale = 6'd12;
      idle(2);
      push_exp(8'h5A, 1'b1, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8, 0);
      idle(20);

      // false start: 3 low cycles
      prescale = 6'd8;
      idle(2);
      line = 1'b0;
      repeat (3) @(negedge clk_RX);
      idle(30);
      chk("glitch_pulses", sg_cnt, 32'd1);
      chk("glitch_busy",   {31'd0, bus.busy}, 32'd0);
      chk("glitch_en",     {31'd0, bus.edge_cnt_enable}, 32'd0);
      chk("glitch_no_dv",  dv_cnt, n_valid_exp);

      // x32 odd parity, back-to-back, with a mid-bit spike in the first frame
      prescale = 6'd32;
      PAR_EN   = 1'b1;
      PAR_TYP  = 1'b1;
      idle(2);
      gl_arm = 1'b1;
      push_exp(8'h81, 1'b1, 1'b0, 1'b0);
      push_exp(8'h7E, 1'b1, 1'b0, 1'b0);
      send_frame(8'h81, 1'b1, 1'b1, 1'b1, 32, 0);
      send_frame(8'h7E, 1'b1, 1'b1, 1'b1, 32, 0);
      idle(80);
      chk("spike_injected", {31'd0, gl_done}, 32'd1);
      chk("b2b_dv_count", dv_time.size(), n_valid_exp);
      if (dv_time.size() >= 2) begin
         // a zero-idle frame is picked up in the first IDLE cycle, so the
         // spacing is one frame time give or take the one-cycle re-align
         gap = dv_time[dv_time.size()-1] - dv_time[dv_time.size()-2];
         chk("b2b_gap_ok", {31'd0, (gap >= 351 && gap <= 353)}, 32'd1);
      end

      // reset mid-data aborts the frame
      prescale = 6'd8;
      PAR_EN   = 1'b1;
      PAR_TYP  = 1'b0;
      idle(2);
      send_frame(8'h55, 1'b1, 1'b0, 1'b1, 8, 4);
      rst  = 1'b0;
      line = 1'b1;
      @(negedge clk_RX);
      chk_reset_outs("rst_mid");
      repeat (4) @(negedge clk_RX);
      chk("rst_hold_P_DATA", {24'd0, bus.P_DATA}, 32'd0);
      rst      = 1'b1;
      exp_last = 8'h00;
      idle(10);
      push_exp(8'h12, 1'b1, 1'b0, 1'b0);
      send_frame(8'h12, 1'b1, 1'b0, 1'b1, 8, 0);
      idle(20);

      wait_n = 0;
      while (sbq.size() != 0 && wait_n < 2000) begin
         @(negedge clk_RX);
         wait_n++;
      end
      chk("sb_drained", sbq.size(), 32'd0);
      chk("dv_total",   dv_cnt, n_valid_exp);
      chk("final_busy", {31'd0, bus.busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Frame controller for the UART receiver. It sequences the RX edge/bit counter (drives its enable and parity-enable inputs, consumes its edge_cnt/bit_cnt/edge_cnt_max outputs) and contains the RX input synchronizer, the 3-point majority sampler, the LSB-first deserializer, and the start, parity and stop checks. It sits between the RX_IN pin and the UART RX output register interface, in the clk_RX domain.

Parameters:
SYNC_STAGES, 2, flip-flop stages on RX_IN before use; legal 0..3, where 0 means RX_IN is used directly.

Ports:
clk_RX  in  1  receiver oversampling clock
rst  in  1  synchronous active-low reset
RX_IN  in  1  serial line, idle high
prescale  in  6  oversampling ratio; 8/16/32 legal, any other value treated as 8
PAR_EN  in  1  parity bit present
PAR_TYP  in  1  0 = even parity, 1 = odd parity
edge_cnt  in  6  from counter
bit_cnt  in  4  from counter
edge_cnt_max  in  1  from counter, last oversample of the current bit
edge_cnt_enable  out  1  to counter
par_en_cnt  out  1  to counter PAR_EN; frame-latched copy of PAR_EN
P_DATA  out  8  received byte
data_valid  out  1  1-cycle pulse, P_DATA valid
par_err  out  1  parity error of the last frame
stp_err  out  1  stop (framing) error of the last frame
strt_glitch  out  1  1-cycle pulse on a false start bit
busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset (rst low at a clk_RX edge): state IDLE; all outputs 0; synchronizer flops 1; shift register 0; latched config 0.
- rx_s = RX_IN after SYNC_STAGES flops. All references below to RX use rx_s.
- Config latch: on the IDLE->START transition, capture PAR_EN, PAR_TYP and prescale. The latched values are used for the whole frame. par_en_cnt drives the latched PAR_EN.
- Bit numbering, matching the counter:
  - bit_cnt 0 = start bit
  - bit_cnt 1..8 = data bits, LSB first
  - bit_cnt 9 = parity bit when latched PAR_EN=1, otherwise the stop bit
  - bit_cnt 10 = stop bit when latched PAR_EN=1
- Sampler: let H = prescale/2 (4/8/16). Register rx_s when edge_cnt equals H-1, H and H+1. Vote = majority of the 3 samples, valid from edge_cnt = H+2. Every bit decision below is taken in the cycle where edge_cnt_max=1.
- edge_cnt_enable = 1 in every state except IDLE. It is combinational from the state register.
- FSM:
  - IDLE: on rx_s=0, go to START.
  - START: at edge_cnt_max, vote=0 goes to DATA. vote=1 goes to IDLE and pulses strt_glitch for 1 cycle; par_err and stp_err are unchanged.
  - DATA: at each edge_cnt_max, shift right with vote entering at bit 7. At edge_cnt_max with bit_cnt=8, go to PARITY if latched PAR_EN=1, otherwise to STOP.
  - PARITY: at edge_cnt_max, set the internal par_bad flag to (vote != (^shift XOR latched PAR_TYP)), then go to STOP.
  - STOP: at edge_cnt_max, go to IDLE. In the next cycle:
    - stp_err <= ~vote
    - par_err <= par_bad
    - if vote=1 and par_bad=0: P_DATA <= shift and data_valid=1 for exactly 1 cycle
    - if there is any error: P_DATA is held and data_valid stays 0
- par_bad is cleared on the IDLE->START transition. par_err and stp_err hold their values until the next STOP decision or reset.
- Back-to-back frames: a start edge is accepted from the first IDLE cycle after STOP, with no extra idle bit required. The counter self-clears through its own bit_cnt_max at the stop bit. Leaving START on a glitch drops the enable, which clears the counter.
- RX activity in the middle of a bit is ignored except at the three sample points.
- A low RX held through the stop bit gives stp_err=1. The FSM then returns to IDLE and treats the continuing low as a new start.
- Reset mid-frame aborts the frame with no data_valid and returns to the reset state on that edge.
- Illegal prescale is handled as 8 (H=4), consistent with the counter's default.

Test Plan:
- prescale=8, PAR_EN=1, PAR_TYP=0, SYNC_STAGES=2; send 0xA5 with parity bit 0, stop 1 (88 clk_RX per frame) -> P_DATA=0xA5, data_valid high exactly 1 cycle, par_err=0, stp_err=0, busy low after the frame.
- Same setup, parity bit forced to 1 -> par_err=1, data_valid never asserted, P_DATA keeps its previous value. A following correct frame 0x3C (parity 0) -> par_err=0, P_DATA=0x3C.
- prescale=16, PAR_EN=0; send 0x00 with stop bit 0 -> stp_err=1, no data_valid. Next frame 0xFF with stop 1 -> stp_err=0, P_DATA=0xFF.
- prescale=8; RX_IN low for 3 clk_RX only, then high -> strt_glitch pulses once at the start-bit edge_cnt_max, FSM back in IDLE, edge_cnt_enable=0, no data_valid.
- prescale=32, PAR_EN=1, PAR_TYP=1; two back-to-back frames 0x81 then 0x7E with zero idle between them -> two data_valid pulses 352 cycles apart, P_DATA 0x81 then 0x7E. A single-cycle inverted glitch on a data bit at edge_cnt=16 does not change the received byte.
- rst asserted mid-DATA on frame 0x55, released 5 cycles later, then a valid frame 0x12 -> all outputs 0 during reset, no valid for 0x55, then P_DATA=0x12 with data_valid.
